// File: rtl/instr_controller_pkg.sv
// rtl/instr_controller_pkg.sv - shared types and field positions for the instruction controller
package ctrl_pkg;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    NOOP   = 4'd3,
    LOAD_A = 4'd4,
    LOAD_B = 4'd5,
    STORE  = 4'd6,
    ADD    = 4'd7,
    SUB    = 4'd8,
    HALT   = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'b0000,
    OP_STORE = 4'b0001,
    OP_LOAD  = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_HALT  = 4'b0101
  } opcode_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // LSB positions of the instruction fields within IR
  localparam int OP_LSB      = 12;
  localparam int RA_LSB      = 8;
  localparam int RB_LSB      = 4;
  localparam int RD_LSB      = 0;
  localparam int LD_ADDR_LSB = 4;
  localparam int ST_ADDR_LSB = 0;

endpackage

// File: rtl/instr_controller_if.sv
// rtl/instr_controller_if.sv - controller-to-datapath bus: instruction in, control strobes out
interface instr_controller_if #(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
);
  logic [15:0]        IR;
  logic               PC_clr;
  logic               PC_up;
  logic               IR_ld;
  logic [DADDR_W-1:0] D_addr;
  logic               D_wr;
  logic               RF_s;
  logic [RADDR_W-1:0] RF_W_addr;
  logic               RF_W_en;
  logic [RADDR_W-1:0] RF_Ra_addr;
  logic [RADDR_W-1:0] RF_Rb_addr;
  logic [2:0]         ALU_s0;
  logic [3:0]         OutState;

  modport master (
    input  IR,
    output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState
  );

  modport slave (
    output IR,
    input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState
  );
endinterface

// File: rtl/instr_controller.sv
// rtl/instr_controller.sv - fetch/decode/execute FSM with Moore outputs decoded from state and IR
// Optional INSTR_CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt instead of executing as NOOP.
module instr_controller
  import ctrl_pkg::*;
#(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  logic                Clk,
  input  logic                Clr,
  instr_controller_if.master  bus
);

  state_t  state;
  state_t  state_nxt;
  opcode_t op;

  assign op = opcode_t'(bus.IR[OP_LSB +: 4]);

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:   state_nxt = FETCH;
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_NOOP:  state_nxt = NOOP;
          OP_STORE: state_nxt = STORE;
          OP_LOAD:  state_nxt = LOAD_A;
          OP_ADD:   state_nxt = ADD;
          OP_SUB:   state_nxt = SUB;
          OP_HALT:  state_nxt = HALT;
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
          default:  state_nxt = HALT;
`else
          default:  state_nxt = NOOP;
`endif
        endcase
      end
      NOOP:   state_nxt = FETCH;
      LOAD_A: state_nxt = LOAD_B;
      LOAD_B: state_nxt = FETCH;
      STORE:  state_nxt = FETCH;
      ADD:    state_nxt = FETCH;
      SUB:    state_nxt = FETCH;
      HALT:   state_nxt = HALT;
      default: state_nxt = INIT;
    endcase
  end

  // Everything defaults to 0 so idle states present a deterministic bus
  always_comb begin
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.IR_ld      = 1'b0;
    bus.D_addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.ALU_s0     = ALU_PASS;
    case (state)
      INIT:  bus.PC_clr = 1'b1;
      FETCH: begin
        bus.IR_ld = 1'b1;
        bus.PC_up = 1'b1;
      end
      LOAD_A, LOAD_B: begin
        bus.D_addr    = bus.IR[LD_ADDR_LSB +: DADDR_W];
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = bus.IR[RD_LSB +: RADDR_W];
        bus.RF_W_en   = (state == LOAD_B);
      end
      STORE: begin
        bus.RF_Ra_addr = bus.IR[RA_LSB +: RADDR_W];
        bus.D_addr     = bus.IR[ST_ADDR_LSB +: DADDR_W];
        bus.D_wr       = 1'b1;
      end
      ADD, SUB: begin
        bus.RF_Ra_addr = bus.IR[RA_LSB +: RADDR_W];
        bus.RF_Rb_addr = bus.IR[RB_LSB +: RADDR_W];
        bus.RF_W_addr  = bus.IR[RD_LSB +: RADDR_W];
        bus.RF_W_en    = 1'b1;
        bus.ALU_s0     = (state == ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  assign bus.OutState = state;

endmodule

// File: tb/tb_instr_controller.sv
// tb/tb_instr_controller.sv - program-level reference model driving IR/PC like the datapath
// Honours INSTR_CTRL_ILLEGAL_TRAP_EN when choosing the expected path for undefined opcodes.
module tb_instr_controller;

  logic Clk = 1'b0;
  logic Clr = 1'b1;

  instr_controller_if #(.DADDR_W(8), .RADDR_W(4)) bus ();

  instr_controller #(.DADDR_W(8), .RADDR_W(4)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int st;
    int ir;
  } step_t;

  logic [15:0] imem [128];
  step_t       steps[$];

  localparam int HALT_HOLD = 20;

  function automatic void push_step(input int st, input int ir);
    step_t s;
    s.st = st;
    s.ir = ir;
    steps.push_back(s);
  endfunction

  function automatic void push_halt(input int ir);
    for (int k = 0; k < HALT_HOLD; k++) push_step(9, ir);
  endfunction

  // Expected state walk of the whole program from the instruction semantics
  function automatic void build_expect();
    int pc;
    int ir;
    int op;
    steps.delete();
    push_step(0, 0);
    pc = 0;
    for (int n = 0; n < 128; n++) begin
      ir = int'(imem[pc]);
      push_step(1, ir);
      pc = (pc + 1) % 128;
      push_step(2, ir);
      op = (ir >> 12) & 15;
      case (op)
        0: push_step(3, ir);
        1: push_step(6, ir);
        2: begin push_step(4, ir); push_step(5, ir); end
        3: push_step(7, ir);
        4: push_step(8, ir);
        5: begin push_halt(ir); return; end
        default: begin
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
          push_halt(ir);
          return;
`else
          push_step(3, ir);
`endif
        end
      endcase
    end
  endfunction

  // {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, W_addr, W_en, Ra, Rb, ALU}
  function automatic logic [28:0] expect_outs(input int st, input int ir);
    logic pc_clr, pc_up, ir_ld, d_wr, rf_s, w_en;
    logic [7:0] d_addr;
    logic [3:0] w_addr, ra, rb;
    logic [2:0] alu;
    {pc_clr, pc_up, ir_ld, d_wr, rf_s, w_en} = '0;
    d_addr = '0; w_addr = '0; ra = '0; rb = '0; alu = '0;
    case (st)
      0: pc_clr = 1'b1;
      1: begin pc_up = 1'b1; ir_ld = 1'b1; end
      4, 5: begin
        d_addr = 8'((ir >> 4) & 255);
        rf_s   = 1'b1;
        w_addr = 4'(ir & 15);
        w_en   = (st == 5);
      end
      6: begin
        ra     = 4'((ir >> 8) & 15);
        d_addr = 8'(ir & 255);
        d_wr   = 1'b1;
      end
      7, 8: begin
        ra     = 4'((ir >> 8) & 15);
        rb     = 4'((ir >> 4) & 15);
        w_addr = 4'(ir & 15);
        w_en   = 1'b1;
        alu    = (st == 7) ? 3'd1 : 3'd2;
      end
      default: ;
    endcase
    return {pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, w_addr, w_en, ra, rb, alu};
  endfunction

  function automatic logic [28:0] dut_outs();
    return {bus.PC_clr, bus.PC_up, bus.IR_ld, bus.D_addr, bus.D_wr, bus.RF_s,
            bus.RF_W_addr, bus.RF_W_en, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.ALU_s0};
  endfunction

  // Resets, then steps the program; abort_at >= 0 fires an async reset mid-run
  task automatic run_program(input string name, input int abort_at);
    int pc_m;
    logic p_clr, p_up, p_ld;
    build_expect();
    Clr = 1'b1;
    bus.IR = 16'h0000;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check({name, ":reset_state"}, 64'(bus.OutState), 64'(steps[0].st));
    check({name, ":reset_outs"}, 64'(dut_outs()), 64'(expect_outs(steps[0].st, 0)));
    p_clr = bus.PC_clr; p_up = bus.PC_up; p_ld = bus.IR_ld;
    pc_m = 0;
    Clr = 1'b0;
    for (int i = 1; i < steps.size(); i++) begin
      @(posedge Clk);
      #1;
      if (p_ld) bus.IR = imem[pc_m];
      if (p_clr)     pc_m = 0;
      else if (p_up) pc_m = (pc_m + 1) % 128;
      @(negedge Clk);
      check({name, ":state"}, 64'(bus.OutState), 64'(steps[i].st));
      check({name, ":outs"}, 64'(dut_outs()), 64'(expect_outs(steps[i].st, steps[i].ir)));
      p_clr = bus.PC_clr; p_up = bus.PC_up; p_ld = bus.IR_ld;
      if (i == abort_at) begin
        #2 Clr = 1'b1;
        #1;
        check({name, ":async_state"}, 64'(bus.OutState), 64'd0);
        check({name, ":async_outs"}, 64'(dut_outs()), 64'(expect_outs(0, 0)));
        break;
      end
    end
  endtask

  task automatic clear_imem();
    for (int a = 0; a < 128; a++) imem[a] = 16'h0000;
  endtask

  initial begin
    bus.IR = 16'h0000;

    clear_imem();
    imem[0] = 16'h3125;
    imem[1] = 16'h2A37;
    imem[2] = 16'h14C8;
    imem[3] = 16'h4FE1;
    imem[4] = 16'h0000;
    imem[5] = 16'h5000;
    run_program("directed", -1);

    clear_imem();
    imem[0] = 16'h2A37;
    imem[1] = 16'h5000;
    run_program("midreset", 3);

    clear_imem();
    imem[0] = 16'hF000;
    imem[1] = 16'h7123;
    imem[2] = 16'h5000;
    run_program("illegal", -1);

    for (int p = 0; p < 6; p++) begin
      int len;
      clear_imem();
      len = int'($urandom_range(4, 12));
      for (int a = 0; a < len; a++) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'd5 && $urandom_range(0, 3) != 0) op = 4'd3;
        imem[a] = {op, 12'($urandom)};
      end
      imem[len] = 16'h5000;
      run_program($sformatf("rand%0d", p), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
